// File: rtl/vbit_pkg.sv
// Shared definitions for the vector bitwise lane: op encodings, sequencer states
// and the VRF element address layout.
package vbit_pkg;

  localparam int VBIT_NUM_REGS = 32;
  localparam int VBIT_VLMAX    = 8;
  localparam int VBIT_REG_W    = $clog2(VBIT_NUM_REGS);
  localparam int VBIT_IDX_W    = $clog2(VBIT_VLMAX);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // VRF element address: register number in the upper bits, element index below.
  typedef struct packed {
    logic [VBIT_REG_W-1:0] vreg;
    logic [VBIT_IDX_W-1:0] idx;
  } vrf_addr_t;

endpackage

// File: rtl/bitwise_operation_unit.sv
// 32-bit combinational bitwise unit shared by the bitwise lane.
// The reserved opcode produces an all-zero result.
module bitwise_operation_unit
  import vbit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vbitwise_seq_ctrl.sv
// Element-by-element sequencer for vand/vor/vxor over the lane's VRF ports.
// Optional build macro VBIT_MASK_EN adds a per-element write mask latched at accept.
module vbitwise_seq_ctrl
  import vbit_pkg::*;
#(
  parameter int NUM_REGS = VBIT_NUM_REGS,
  parameter int VLMAX    = VBIT_VLMAX,
  parameter int DATA_W   = 32,
  parameter int REG_W    = $clog2(NUM_REGS),
  parameter int IDX_W    = $clog2(VLMAX),
  parameter int CNT_W    = IDX_W + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef VBIT_MASK_EN
  input  logic [VLMAX-1:0]       mask,
`endif
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [REG_W-1:0]       cmd_vs1,
  input  logic [REG_W-1:0]       cmd_vs2,
  input  logic [REG_W-1:0]       cmd_vd,
  input  logic [CNT_W-1:0]       cmd_vl,
  output logic                   rd_en,
  output logic [REG_W+IDX_W-1:0] rd_addr_a,
  output logic [REG_W+IDX_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0]      rd_data_a,
  input  logic [DATA_W-1:0]      rd_data_b,
  output logic                   wr_en,
  output logic [REG_W+IDX_W-1:0] wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   busy,
  output logic                   done
);

  state_t             state;
  logic [1:0]         op_q;
  logic [REG_W-1:0]   vs1_q;
  logic [REG_W-1:0]   vs2_q;
  logic [REG_W-1:0]   vd_q;
  logic [CNT_W-1:0]   vl_q;
  logic [IDX_W-1:0]   ri;
  logic [VLMAX-1:0]   mask_q;
  logic               vld_p1;
  logic [IDX_W-1:0]   wr_idx_p1;
  logic [CNT_W-1:0]   eff_vl;
  logic [VLMAX-1:0]   mask_in;
  logic [DATA_W-1:0]  unit_y;

  assign eff_vl = (cmd_vl > CNT_W'(VLMAX)) ? CNT_W'(VLMAX) : cmd_vl;

`ifdef VBIT_MASK_EN
  assign mask_in = mask;
`else
  assign mask_in = '1;
`endif

  // Stage p0: sequencer issues reads at index ri
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      ri        <= '0;
      op_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vd_q      <= '0;
      vl_q      <= '0;
      mask_q    <= '0;
      vld_p1    <= 1'b0;
      wr_idx_p1 <= '0;
    end else begin
      vld_p1    <= rd_en & mask_q[ri];
      wr_idx_p1 <= ri;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            vs1_q     <= cmd_vs1;
            vs2_q     <= cmd_vs2;
            vd_q      <= cmd_vd;
            vl_q      <= eff_vl;
            mask_q    <= mask_in;
            ri        <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (eff_vl == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              rd_en <= 1'b1;
            end
          end
        end
        RUN: begin
          if ({1'b0, ri} == vl_q - CNT_W'(1)) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            ri <= ri + IDX_W'(1);
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_addr_a = {vs1_q, ri};
  assign rd_addr_b = {vs2_q, ri};

  // Stage p1: read data returns, result written back at the tracked index
  bitwise_operation_unit #(
    .DATA_W(DATA_W)
  ) u_bitwise_unit (
    .a  (rd_data_a),
    .b  (rd_data_b),
    .op (op_q),
    .y  (unit_y)
  );

  assign wr_en   = vld_p1;
  assign wr_addr = {vd_q, wr_idx_p1};
  assign wr_data = vld_p1 ? unit_y : '0;

endmodule

// File: tb/tb_vbitwise_seq_ctrl.sv
// Directed bench for vbitwise_seq_ctrl with a behavioural VRF (1-cycle read latency).
module tb_vbitwise_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_vs1, cmd_vs2, cmd_vd;
  logic [3:0]  cmd_vl;
  logic        rd_en;
  logic [7:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, done;
  logic [7:0]  mask;

  always #5 clk = ~clk;

  vbitwise_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef VBIT_MASK_EN
    .mask      (mask),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_vs1   (cmd_vs1),
    .cmd_vs2   (cmd_vs2),
    .cmd_vd    (cmd_vd),
    .cmd_vl    (cmd_vl),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  // Behavioural VRF; preloads go through the same write port.
  logic [31:0] vrf [256];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= vrf[rd_addr_a];
      rd_data_b <= vrf[rd_addr_b];
    end
    if (pl_we) vrf[pl_addr] <= pl_data;
    else if (wr_en) vrf[wr_addr] <= wr_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int hs_cnt = 0, hs_cyc = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0;
  int          wr_cyc_q[$];
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        hs_cnt <= hs_cnt + 1;
        hs_cyc <= cyc;
      end
      if (rd_en) rd_cnt <= rd_cnt + 1;
      if (wr_en) begin
        wr_cyc_q.push_back(cyc);
        wr_addr_q.push_back(wr_addr);
        wr_data_q.push_back(wr_data);
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  int n_vec = 0, n_err = 0;
  int b_wr, b_rd, b_done, b_hs;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic pl(input int addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    pl_we   = 1'b1;
    pl_addr = addr[7:0];
    pl_data = data;
    @(posedge clk);
    #1;
    pl_we = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input int vs1, input int vs2, input int vd,
                          input int vl, input logic [7:0] m);
    b_wr   = wr_cyc_q.size();
    b_rd   = rd_cnt;
    b_done = done_cnt;
    b_hs   = hs_cnt;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_vs1   = vs1[4:0];
    cmd_vs2   = vs2[4:0];
    cmd_vd    = vd[4:0];
    cmd_vl    = vl[3:0];
    mask      = m;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b11;
    cmd_vs1   = 5'd31;
    cmd_vs2   = 5'd31;
    cmd_vd    = 5'd31;
    cmd_vl    = 4'd7;
    check_val("handshake", 64'(hs_cnt - b_hs), 64'd1);
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (done_cnt == b_done && k < bound) begin
      @(posedge clk);
      k++;
    end
    check_val("done_seen", 64'(done_cnt - b_done), 64'd1);
    #2;
    check_val("ready_after_done", 64'(cmd_ready), 64'd1);
    check_val("idle_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_vs1 = '0; cmd_vs2 = '0;
    cmd_vd = '0; cmd_vl = '0; mask = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_rd_en", 64'(rd_en), 64'd0);
    check_val("rst_wr_en", 64'(wr_en), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_rd_addr_a", 64'(rd_addr_a), 64'd0);
    check_val("rst_wr_addr", 64'(wr_addr), 64'd0);
    check_val("rst_wr_data", 64'(wr_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // AND, vl=4: vs1=r1, vs2=r2, vd=r3
    for (int i = 0; i < 4; i++) begin
      pl(8 + i, 32'hFFFF0000);
      pl(16 + i, 32'h0F0F0F0F);
    end
    send_cmd(2'b00, 1, 2, 3, 4, 8'hFF);
    wait_done(30);
    check_val("and_wr_count", 64'(wr_cyc_q.size() - b_wr), 64'd4);
    check_val("and_rd_count", 64'(rd_cnt - b_rd), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("and_wr_addr", 64'(wr_addr_q[b_wr + i]), 64'(24 + i));
      check_val("and_wr_data", 64'(wr_data_q[b_wr + i]), 64'h0F0F0000);
      check_val("and_wr_cycle", 64'(wr_cyc_q[b_wr + i]), 64'(hs_cyc + 2 + i));
      check_val("and_vrf", 64'(vrf[24 + i]), 64'h0F0F0000);
    end
    check_val("and_done_cycle", 64'(done_cyc), 64'(hs_cyc + 6));

    // XOR, vl=8, vd==vs1 (r4), vs2=r5
    for (int i = 0; i < 8; i++) begin
      pl(32 + i, 32'hA5A50000 | 32'(i));
      pl(40 + i, 32'h0000FFFF);
    end
    send_cmd(2'b10, 4, 5, 4, 8, 8'hFF);
    wait_done(30);
    check_val("xor_wr_count", 64'(wr_cyc_q.size() - b_wr), 64'd8);
    check_val("xor_rd_count", 64'(rd_cnt - b_rd), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check_val("xor_wr_addr", 64'(wr_addr_q[b_wr + i]), 64'(32 + i));
      check_val("xor_vrf", 64'(vrf[32 + i]), 64'(32'hA5A5FFFF - 32'(i)));
    end
    check_val("xor_done_cycle", 64'(done_cyc), 64'(hs_cyc + 10));

    // vl=0: no traffic, done right after accept
    send_cmd(2'b01, 1, 2, 9, 0, 8'hFF);
    wait_done(10);
    check_val("vl0_wr_count", 64'(wr_cyc_q.size() - b_wr), 64'd0);
    check_val("vl0_rd_count", 64'(rd_cnt - b_rd), 64'd0);
    check_val("vl0_done_cycle", 64'(done_cyc), 64'(hs_cyc + 1));
    check_val("vl0_ready_cycle", 64'(cyc), 64'(hs_cyc + 2));

    // Reserved op with vl=15 clamps to 8 and writes zeros
    for (int i = 0; i < 8; i++) begin
      pl(48 + i, 32'h13579BDF);
      pl(56 + i, 32'h2468ACE0);
      pl(64 + i, 32'hDEADBEEF);
    end
    pl(72, 32'hCAFEF00D);
    send_cmd(2'b11, 6, 7, 8, 15, 8'hFF);
    wait_done(30);
    check_val("clamp_wr_count", 64'(wr_cyc_q.size() - b_wr), 64'd8);
    check_val("clamp_done_cycle", 64'(done_cyc), 64'(hs_cyc + 10));
    for (int i = 0; i < 8; i++)
      check_val("rsvd_vrf", 64'(vrf[64 + i]), 64'd0);
    check_val("clamp_neighbour", 64'(vrf[72]), 64'hCAFEF00D);

    // Reset after two writes of an OR with vl=6
    for (int i = 0; i < 6; i++) begin
      pl(80 + i, 32'h12340000 + 32'(i));
      pl(88 + i, 32'h00FF00F3);
      pl(96 + i, 32'h55555555);
    end
    send_cmd(2'b01, 10, 11, 12, 6, 8'hFF);
    begin
      int k = 0;
      while (wr_cyc_q.size() - b_wr < 2 && k < 20) begin
        @(posedge clk);
        k++;
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_val("abort_wr_en", 64'(wr_en), 64'd0);
    check_val("abort_rd_en", 64'(rd_en), 64'd0);
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    check_val("abort_ready", 64'(cmd_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_wr_count", 64'(wr_cyc_q.size() - b_wr), 64'd2);
    check_val("abort_no_done", 64'(done_cnt - b_done), 64'd0);
    check_val("abort_vrf0", 64'(vrf[96]), 64'h12FF00F3);
    check_val("abort_vrf1", 64'(vrf[97]), 64'h12FF00F3);
    check_val("abort_vrf2", 64'(vrf[98]), 64'h55555555);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean AND after reset release: vd=r13
    send_cmd(2'b00, 10, 11, 13, 3, 8'hFF);
    wait_done(20);
    check_val("post_wr_count", 64'(wr_cyc_q.size() - b_wr), 64'd3);
    check_val("post_done_cycle", 64'(done_cyc), 64'(hs_cyc + 5));
    check_val("post_vrf0", 64'(vrf[104]), 64'h00340000);
    check_val("post_vrf1", 64'(vrf[105]), 64'h00340001);
    check_val("post_vrf2", 64'(vrf[106]), 64'h00340002);

`ifdef VBIT_MASK_EN
    // Masked XOR: only idx 0,2,5,7 written to r14, timing unchanged
    send_cmd(2'b10, 6, 7, 14, 8, 8'b10100101);
    wait_done(30);
    check_val("mask_wr_count", 64'(wr_cyc_q.size() - b_wr), 64'd4);
    check_val("mask_rd_count", 64'(rd_cnt - b_rd), 64'd8);
    check_val("mask_addr0", 64'(wr_addr_q[b_wr + 0]), 64'd112);
    check_val("mask_addr1", 64'(wr_addr_q[b_wr + 1]), 64'd114);
    check_val("mask_addr2", 64'(wr_addr_q[b_wr + 2]), 64'd117);
    check_val("mask_addr3", 64'(wr_addr_q[b_wr + 3]), 64'd119);
    check_val("mask_data", 64'(wr_data_q[b_wr]), 64'h373F373F);
    check_val("mask_done_cycle", 64'(done_cyc), 64'(hs_cyc + 10));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vbitwise_seq_ctrl.md
Name: vbitwise_seq_ctrl

Overview:
Sequencer that executes one vector bitwise instruction (vand/vor/vxor) element-by-element through an instance of the team's 32-bit bitwise operation unit. It accepts a command over a valid/ready handshake and streams operand reads from the vector register file (VRF), one element per cycle. It writes each result back and signals completion. It sits between the coprocessor issue stage and the VRF ports owned by the bitwise lane.

Parameters:
NUM_REGS, 32, number of architectural vector registers; REG_W = clog2(NUM_REGS)
VLMAX, 8, max elements per register; IDX_W = clog2(VLMAX), VLMAX power of two
CNT_W, IDX_W+1, width of vector-length fields

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept command
cmd_op  in  2  00 AND, 01 OR, 10 XOR, 11 reserved (writes zero)
cmd_vs1  in  REG_W  source register A
cmd_vs2  in  REG_W  source register B
cmd_vd  in  REG_W  destination register
cmd_vl  in  CNT_W  element count
rd_en  out  1  VRF read strobe, both ports
rd_addr_a  out  REG_W+IDX_W  {vs1, idx}
rd_addr_b  out  REG_W+IDX_W  {vs2, idx}
rd_data_a  in  32  read data A, valid exactly 1 cycle after rd_en
rd_data_b  in  32  read data B, valid exactly 1 cycle after rd_en
wr_en  out  1  VRF write strobe
wr_addr  out  REG_W+IDX_W  {vd, idx}
wr_data  out  32  result from bitwise unit
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of instruction

Behaviour:
- Reset (async assert, sync deassert): state=IDLE. cmd_ready=1. rd_en=wr_en=busy=done=0. Addresses, wr_data and counters=0.
- cmd_ready=1 only in IDLE. Handshake fires when cmd_valid&cmd_ready. On handshake, latch op/vs1/vs2/vd and eff_vl=min(cmd_vl,VLMAX).
- FSM IDLE->RUN on handshake with eff_vl>0. IDLE->DONE on handshake with eff_vl==0; no reads or writes occur.
- RUN: rd_en=1 with read index ri, ri increments 0..eff_vl-1, one element per cycle. RUN->DRAIN after issuing index eff_vl-1.
- Write pipe: a registered flag/index tracks each read. In the cycle after read ri, wr_en=1, wr_addr={vd,ri} and wr_data=BitwiseOperationUnit(rd_data_a,rd_data_b,op) (combinational). Writes are therefore in order, one per cycle.
- DRAIN: issues the final write, rd_en=0 ->DONE.
- DONE: done=1 for exactly one cycle ->IDLE. cmd_ready rises the following cycle.
- Latency: handshake at cycle T; first read at T+1; first write at T+2; last write at T+1+eff_vl; done at T+2+eff_vl. Back-to-back command accepted no earlier than T+3+eff_vl.
- Overlap vd==vs1 or vd==vs2: legal. Element i is read before element i is written, so old values are used.
- cmd_vl>VLMAX: clamped silently.
- Reset mid-operation: abort immediately. No further rd_en/wr_en. No done pulse.
- cmd_* inputs are ignored while busy.

Optional Feature:
VBIT_MASK_EN. When defined, adds input mask (VLMAX bits, sampled and latched at the handshake). An element whose latched mask bit is 0 still reads but suppresses wr_en, so the destination is undisturbed. Cycle count is unchanged. When undefined, there is no mask port and all elements are written.

Decomposition:
- Shared package vbit_pkg holds:
  - op encoding localparams (OP_AND/OP_OR/OP_XOR/OP_RSVD)
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - the VRF address struct {reg, idx}
- One sub-module: the existing BitwiseOperationUnit, instantiated unchanged.
- Counters and FSM stay in this module.

Test Plan:
- AND, vl=4, vs1 elems 0xFFFF0000…, vs2 0x0F0F0F0F -> 4 writes, each 0x0F0F0000, to {vd,0..3} on consecutive cycles; done at T+6.
- XOR, vl=VLMAX=8, vd==vs1 -> every element becomes A^B using the pre-instruction A; exactly 8 wr_en cycles.
- cmd_vl=0 -> no rd_en, no wr_en; done pulses at T+1; cmd_ready back at T+2.
- cmd_vl=15 with VLMAX=8 -> exactly 8 writes; op=11 -> wr_data=0.
- rst_n asserted after 2 writes of vl=6 -> outputs zero immediately; no done; a new command after release runs cleanly.
- With VBIT_MASK_EN, mask=0b10100101 -> wr_en only for idx 0,2,5,7; done timing identical to the unmasked run.
